// File: rtl/dwt_2d_sched.sv
// Three-pass scheduler (rows, low-band columns, high-band columns) for a shared 1-D lifting engine.
// Each line is issued one cycle after the engine reports done; line bases advance by addition only.
module dwt_2d_sched #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start_i,
    output logic              eng_start_o,
    input  logic              eng_done_i,
    output logic [ADDR_W-1:0] eng_base_o,
    output logic [ADDR_W-1:0] eng_stride_o,
    output logic [LEN_W-1:0]  eng_len_o,
    output logic [1:0]        eng_mode_o,
    output logic [LEN_W-1:0]  line_idx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              d1_over_o,
    output logic              d2_low_over_o,
    output logic              d2_high_over_o
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {M_ROW = 2'd0, M_COL_LOW = 2'd1, M_COL_HIGH = 2'd2} mode_t;

    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] HALF_A   = ADDR_W'(IMG_W / 2);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  W_L      = LEN_W'(IMG_W);
    localparam logic [LEN_W-1:0]  H_L      = LEN_W'(IMG_H);
    localparam logic [LEN_W-1:0]  ROW_LAST = LEN_W'(IMG_H - 1);
    localparam logic [LEN_W-1:0]  COL_LAST = LEN_W'(IMG_W / 2 - 1);
    localparam logic [TMR_W-1:0]  TMR_END  = TMR_W'(TIMEOUT);

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [LEN_W-1:0]    line_q, line_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                err_q, err_d;
    logic                d1_q, d1_d;
    logic                d2l_q, d2l_d;
    logic                d2h_q, d2h_d;
    logic                line_last;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            mode_q   <= M_ROW;
            line_q   <= '0;
            base_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            timer_q  <= '0;
            err_q    <= 1'b0;
            d1_q     <= 1'b0;
            d2l_q    <= 1'b0;
            d2h_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            line_q   <= line_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            len_q    <= len_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            d1_q     <= d1_d;
            d2l_q    <= d2l_d;
            d2h_q    <= d2h_d;
        end
    end

    assign line_last = (mode_q == M_ROW) ? (line_q == ROW_LAST) : (line_q == COL_LAST);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        line_d   = line_q;
        base_d   = base_q;
        stride_d = stride_q;
        len_d    = len_q;
        timer_d  = timer_q;
        err_d    = err_q;
        d1_d     = d1_q;
        d2l_d    = d2l_q;
        d2h_d    = d2h_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d    = 1'b0;
                    d1_d     = 1'b0;
                    d2l_d    = 1'b0;
                    d2h_d    = 1'b0;
                    mode_d   = M_ROW;
                    line_d   = '0;
                    base_d   = '0;
                    stride_d = ONE_A;
                    len_d    = W_L;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (eng_done_i) begin
                    state_d = S_ISSUE;
                    if (!line_last) begin
                        line_d = line_q + 1'b1;
                        base_d = base_q + ((mode_q == M_ROW) ? W_A : ONE_A);
                    end else begin
                        line_d = '0;
                        // Pass switch reloads geometry; COL_HIGH keeps stride/len from COL_LOW.
                        case (mode_q)
                            M_ROW: begin
                                d1_d     = 1'b1;
                                mode_d   = M_COL_LOW;
                                base_d   = '0;
                                stride_d = W_A;
                                len_d    = H_L;
                            end
                            M_COL_LOW: begin
                                d2l_d  = 1'b1;
                                mode_d = M_COL_HIGH;
                                base_d = HALF_A;
                            end
                            default: begin
                                d2h_d   = 1'b1;
                                state_d = S_DONE;
                            end
                        endcase
                    end
                end else if (timer_d == TMR_END) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign eng_start_o    = (state_q == S_ISSUE) && !sys_rst;
    assign eng_base_o     = base_q;
    assign eng_stride_o   = stride_q;
    assign eng_len_o      = len_q;
    assign eng_mode_o     = mode_q;
    assign line_idx_o     = line_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign err_o          = err_q;
    assign d1_over_o      = d1_q;
    assign d2_low_over_o  = d2l_q;
    assign d2_high_over_o = d2h_q;

endmodule

// File: tb/tb_dwt_2d_sched.sv
// Bench for dwt_2d_sched: cycle-level model of the expected line schedule, driven by an
// engine responder with fixed or random latency, start/done noise, timeouts and reset aborts.
module tb_dwt_2d_sched;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int TO  = 255;
    localparam int N   = H + W;
    localparam int BIG = 1 << 30;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       start_i = 1'b0;
    logic       eng_done_i = 1'b0;
    logic       eng_start_o;
    logic [7:0] eng_base_o, eng_stride_o, eng_len_o, line_idx_o;
    logic [1:0] eng_mode_o;
    logic       busy_o, done_o, err_o, d1_over_o, d2_low_over_o, d2_high_over_o;

    int nvec = 0;
    int nerr = 0;
    int exp_base[N], exp_stride[N], exp_len[N], exp_mode[N], exp_line[N];

    dwt_2d_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(8), .LEN_W(8), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start_i(start_i),
        .eng_start_o(eng_start_o), .eng_done_i(eng_done_i),
        .eng_base_o(eng_base_o), .eng_stride_o(eng_stride_o), .eng_len_o(eng_len_o),
        .eng_mode_o(eng_mode_o), .line_idx_o(line_idx_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .d1_over_o(d1_over_o), .d2_low_over_o(d2_low_over_o),
        .d2_high_over_o(d2_high_over_o)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [40:0] all_outs();
        return {eng_start_o, busy_o, done_o, err_o, d1_over_o, d2_low_over_o, d2_high_over_o,
                eng_mode_o, eng_base_o, eng_stride_o, eng_len_o, line_idx_o};
    endfunction

    task automatic build_table();
        for (int r = 0; r < H; r++) begin
            exp_base[r] = r * W; exp_stride[r] = 1; exp_len[r] = W; exp_mode[r] = 0; exp_line[r] = r;
        end
        for (int c = 0; c < W / 2; c++) begin
            exp_base[H + c] = c;                 exp_stride[H + c] = W; exp_len[H + c] = H;
            exp_mode[H + c] = 1;                 exp_line[H + c] = c;
            exp_base[H + W/2 + c] = W / 2 + c;   exp_stride[H + W/2 + c] = W; exp_len[H + W/2 + c] = H;
            exp_mode[H + W/2 + c] = 2;           exp_line[H + W/2 + c] = c;
        end
    endtask

    // Runs one transform from IDLE; cycle 0 is the cycle start_i is presented.
    task automatic run_transform(input int lat, input bit rand_lat, input bit noise,
                                 input int silent, input int reset_at);
        int s[N+1];
        int d[N];
        int nstart, abort_at, done_cyc, end_cyc, k;
        int rise[3];
        int last_line[3];
        bit aborted;
        last_line = '{H - 1, H + W/2 - 1, N - 1};
        s[0] = 1; aborted = 0; nstart = N; abort_at = BIG;
        for (int i = 0; i < N; i++) begin
            if (i == silent) begin
                aborted = 1; abort_at = s[i] + TO + 1; nstart = i + 1;
                break;
            end
            d[i] = s[i] + (rand_lat ? int'($urandom_range(1, 6)) : lat);
            s[i+1] = d[i] + 1;
        end
        for (int p = 0; p < 3; p++)
            rise[p] = (aborted && silent <= last_line[p]) ? BIG : d[last_line[p]] + 1;
        done_cyc = aborted ? BIG : d[N-1] + 1;
        end_cyc  = aborted ? abort_at : d[N-1] + 2;

        nvec++;
        if (busy_o !== 1'b0) begin
            nerr++; $display("FAIL idle_before_start got=%0b exp=0", busy_o);
        end
        start_i = 1'b1; eng_done_i = 1'b0;
        k = 0;
        for (int t = 1; t <= end_cyc; t++) begin
            @(posedge sys_clk); #1;
            if (reset_at >= 0 && t == reset_at + 1) begin
                nvec++;
                if (all_outs() !== '0) begin
                    nerr++; $display("FAIL reset_abort cyc=%0d got=%0h exp=0", t, all_outs());
                end
                sys_rst = 1'b0; start_i = 1'b0; eng_done_i = 1'b0;
                return;
            end
            while (k + 1 < nstart && s[k+1] <= t) k++;
            nvec += 7;
            if (eng_start_o !== (t == s[k])) begin
                nerr++; $display("FAIL eng_start cyc=%0d got=%0b exp=%0b", t, eng_start_o, t == s[k]);
            end
            if (busy_o !== (t < end_cyc)) begin
                nerr++; $display("FAIL busy cyc=%0d got=%0b exp=%0b", t, busy_o, t < end_cyc);
            end
            if (done_o !== (t == done_cyc)) begin
                nerr++; $display("FAIL done cyc=%0d got=%0b exp=%0b", t, done_o, t == done_cyc);
            end
            if (err_o !== (t >= abort_at)) begin
                nerr++; $display("FAIL err cyc=%0d got=%0b exp=%0b", t, err_o, t >= abort_at);
            end
            if (d1_over_o !== (t >= rise[0])) begin
                nerr++; $display("FAIL d1_over cyc=%0d got=%0b exp=%0b", t, d1_over_o, t >= rise[0]);
            end
            if (d2_low_over_o !== (t >= rise[1])) begin
                nerr++; $display("FAIL d2_low cyc=%0d got=%0b exp=%0b", t, d2_low_over_o, t >= rise[1]);
            end
            if (d2_high_over_o !== (t >= rise[2])) begin
                nerr++; $display("FAIL d2_high cyc=%0d got=%0b exp=%0b", t, d2_high_over_o, t >= rise[2]);
            end
            if (t < done_cyc && t < abort_at) begin
                nvec++;
                if ({eng_base_o, eng_stride_o, eng_len_o, eng_mode_o, line_idx_o} !==
                    {8'(exp_base[k]), 8'(exp_stride[k]), 8'(exp_len[k]), 2'(exp_mode[k]), 8'(exp_line[k])}) begin
                    nerr++;
                    $display("FAIL line_fields cyc=%0d line=%0d got base=%0d stride=%0d len=%0d mode=%0d idx=%0d exp base=%0d stride=%0d len=%0d mode=%0d idx=%0d",
                             t, k, eng_base_o, eng_stride_o, eng_len_o, eng_mode_o, line_idx_o,
                             exp_base[k], exp_stride[k], exp_len[k], exp_mode[k], exp_line[k]);
                end
            end
            // Inputs for this cycle, sampled at the next edge.
            start_i = (noise && t < end_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (t == d[k] && !(aborted && k == silent) && t < done_cyc) eng_done_i = 1'b1;
            else if (noise && t == s[k]) eng_done_i = 1'($urandom_range(0, 1));
            else eng_done_i = 1'b0;
            if (reset_at >= 0 && t == reset_at) sys_rst = 1'b1;
        end
        start_i = 1'b0; eng_done_i = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; start_i = 1'b1; eng_done_i = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        nvec++;
        if (all_outs() !== '0) begin
            nerr++; $display("FAIL reset_state got=%0h exp=0", all_outs());
        end
        sys_rst = 1'b0; start_i = 1'b0; eng_done_i = 1'b0;
        @(posedge sys_clk); #1;
        nvec++;
        if (busy_o !== 1'b0) begin
            nerr++; $display("FAIL idle_after_reset got=%0b exp=0", busy_o);
        end
    endtask

    task automatic test_nominal();
        run_transform(3, 0, 0, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_transform(3, 0, 0, -1, -1);
    endtask

    task automatic test_timeout();
        run_transform(3, 0, 0, 2, -1);
        run_transform(3, 0, 0, -1, -1);
    endtask

    task automatic test_robust();
        run_transform(3, 0, 1, -1, -1);
    endtask

    task automatic test_random_latency();
        for (int i = 0; i < 3; i++) run_transform(0, 1, 1, -1, -1);
        run_transform(0, 1, 1, 5 + int'($urandom_range(0, 8)), -1);
    endtask

    task automatic test_reset_mid_pass();
        run_transform(3, 0, 0, -1, 40);
        run_transform(3, 0, 0, -1, -1);
    endtask

    initial begin
        build_table();
        test_reset();
        test_nominal();
        test_back_to_back();
        test_timeout();
        test_robust();
        test_random_latency();
        test_reset_mid_pass();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
